gpio_ctrl_core: RTL and testbench

//  Register-controlled GPIO engine driving the CTRL modport of gpio_if: owns data_out/dir_ctrl, samples data_in.

---
 rtl/gpio_ctrl_core.sv | 93 +++++++++
 tb/tb_gpio_ctrl_core.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl_core.sv
// gpio_ctrl_core: register-controlled GPIO bank with input sync, debounce, edge detect and sticky IRQ status.
// Register map: 0 DATA_OUT, 1 DIR, 2 DATA_IN (ro), 3 IRQ_EN, 4 RISE_EN, 5 FALL_EN, 6 IRQ_STATUS (w1c), 7 reserved.
module gpio_ctrl_core #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] dir_ctrl,
   output logic [WIDTH-1:0] irq_event,
   output logic             irq,
   input  logic             reg_wr_en,
   input  logic [2:0]       reg_wr_addr,
   input  logic [WIDTH-1:0] reg_wr_data,
   input  logic             reg_rd_en,
   input  logic [2:0]       reg_rd_addr,
   output logic [WIDTH-1:0] reg_rd_data,
   output logic             reg_rd_valid
);
   localparam int DEB = DEB_CYCLES > 1 ? DEB_CYCLES : 1;
   localparam int CW  = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES + 1) : 1;

   logic [WIDTH-1:0] sync_r [SYNC_STAGES];
   logic [WIDTH-1:0] sync_q, stable, stable_d, irq_en, rise_en, fall_en, status;
   logic [WIDTH-1:0] q, w1c, rd_mux;
   logic [CW-1:0]    cnt [WIDTH];
   logic [7:0]       we;

   assign sync_q = sync_r[SYNC_STAGES-1];

   always_ff @(posedge clk)
      if (!rst_n) sync_r <= '{default: '0};
      else begin
         sync_r[0] <= data_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      end

   // a pin's stable level flips only after DEB consecutive mismatching samples
   always_ff @(posedge clk)
      if (!rst_n) begin
         cnt    <= '{default: '0};
         stable <= '0;
      end else
         for (int i = 0; i < WIDTH; i++)
            if (sync_q[i] == stable[i]) cnt[i] <= '0;
            else if (cnt[i] == CW'(DEB - 1)) begin
               stable[i] <= sync_q[i];
               cnt[i]    <= '0;
            end else cnt[i] <= cnt[i] + 1'b1;

   assign we  = reg_wr_en ? 8'd1 << reg_wr_addr : 8'd0;
   assign w1c = we[6] ? reg_wr_data : '0;
   assign q   = (stable & ~stable_d & rise_en) | (~stable & stable_d & fall_en);
   assign irq = |(status & irq_en);

   // a new qualified edge wins over a simultaneous w1c of the same bit
   always_ff @(posedge clk)
      if (!rst_n) {data_out, dir_ctrl, irq_en, rise_en, fall_en, status, stable_d, irq_event} <= '0;
      else begin
         stable_d  <= stable;
         irq_event <= q;
         status    <= (status & ~w1c) | q;
         data_out  <= we[0] ? reg_wr_data : data_out;
         dir_ctrl  <= we[1] ? reg_wr_data : dir_ctrl;
         irq_en    <= we[3] ? reg_wr_data : irq_en;
         rise_en   <= we[4] ? reg_wr_data : rise_en;
         fall_en   <= we[5] ? reg_wr_data : fall_en;
      end

   always_comb
      case (reg_rd_addr)
         3'd0:    rd_mux = data_out;
         3'd1:    rd_mux = dir_ctrl;
         3'd2:    rd_mux = stable;
         3'd3:    rd_mux = irq_en;
         3'd4:    rd_mux = rise_en;
         3'd5:    rd_mux = fall_en;
         3'd6:    rd_mux = status;
         default: rd_mux = '0;
      endcase

   always_ff @(posedge clk)
      if (!rst_n) begin
         reg_rd_data  <= '0;
         reg_rd_valid <= 1'b0;
      end else begin
         reg_rd_valid <= reg_rd_en;
         if (reg_rd_en) reg_rd_data <= rd_mux;
      end
endmodule

// File: tb/tb_gpio_ctrl_core.sv
// tb_gpio_ctrl_core: register table, directed corner sequences and random traffic checked against a window-based model.
module tb_gpio_ctrl_core;
   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int DE   = DEB > 1 ? DEB : 1;

   logic       clk = 0, rst_n = 0;
   logic [7:0] data_in = 0, data_out, dir_ctrl, irq_event, reg_wr_data = 0, reg_rd_data;
   logic       irq, reg_wr_en = 0, reg_rd_en = 0, reg_rd_valid;
   logic [2:0] reg_wr_addr = 0, reg_rd_addr = 0;
   int         n_checks = 0, n_fail = 0;
   bit         chk_en = 0;

   gpio_ctrl_core #(.WIDTH(8), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_out(data_out), .dir_ctrl(dir_ctrl),
      .irq_event(irq_event), .irq(irq), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
      .reg_wr_data(reg_wr_data), .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr),
      .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a pin's accepted level flips once the last DE synchronised samples all disagree with it
   logic [7:0] m_dout, m_dir, m_ien, m_ren, m_fen, m_stat, m_stable, m_stable_d, m_ev, m_rd, mq, mnst, mw1c;
   logic       m_rv, mflip;
   logic [7:0] hist[$];

   always @(posedge clk) begin
      if (!rst_n) begin
         {m_dout, m_dir, m_ien, m_ren, m_fen, m_stat, m_stable, m_stable_d, m_ev, m_rd} = '0;
         m_rv = 0;
         hist.delete();
         repeat (SYNC + DE) hist.push_back(8'h00);
      end else begin
         mq = (m_stable & ~m_stable_d & m_ren) | (~m_stable & m_stable_d & m_fen);
         mnst = m_stable;
         for (int i = 0; i < 8; i++) begin
            mflip = 1'b1;
            for (int j = 0; j < DE; j++)
               if (hist[hist.size() - SYNC - j][i] == m_stable[i]) mflip = 1'b0;
            if (mflip) mnst[i] = ~m_stable[i];
         end
         if (reg_rd_en)
            m_rd = reg_rd_addr == 0 ? m_dout : reg_rd_addr == 1 ? m_dir : reg_rd_addr == 2 ? m_stable :
                   reg_rd_addr == 3 ? m_ien : reg_rd_addr == 4 ? m_ren : reg_rd_addr == 5 ? m_fen :
                   reg_rd_addr == 6 ? m_stat : 8'h00;
         m_rv = reg_rd_en;
         mw1c = (reg_wr_en && reg_wr_addr == 6) ? reg_wr_data : 8'h00;
         if (reg_wr_en) begin
            if (reg_wr_addr == 0) m_dout = reg_wr_data;
            if (reg_wr_addr == 1) m_dir = reg_wr_data;
            if (reg_wr_addr == 3) m_ien = reg_wr_data;
            if (reg_wr_addr == 4) m_ren = reg_wr_data;
            if (reg_wr_addr == 5) m_fen = reg_wr_data;
         end
         m_stat = (m_stat & ~mw1c) | mq;
         m_ev = mq;
         m_stable_d = m_stable;
         m_stable = mnst;
         hist.push_back(data_in);
         hist.delete(0);
      end
   end

   always @(negedge clk)
      if (chk_en) begin
         chk("mdl_data_out", data_out, m_dout);
         chk("mdl_dir_ctrl", dir_ctrl, m_dir);
         chk("mdl_irq_event", irq_event, m_ev);
         chk("mdl_irq", irq, |(m_stat & m_ien));
         chk("mdl_rd_valid", reg_rd_valid, m_rv);
         chk("mdl_rd_data", reg_rd_data, m_rd);
      end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      reg_wr_en = 1; reg_wr_addr = a; reg_wr_data = d;
      step();
      reg_wr_en = 0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [7:0] d);
      reg_rd_en = 1; reg_rd_addr = a;
      step();
      reg_rd_en = 0;
      chk("rd_valid_pulse", reg_rd_valid, 1);
      d = reg_rd_data;
   endtask

   typedef struct packed {
      logic [2:0] a;
      logic [7:0] d;
      logic [7:0] exp;
   } vec_t;
   vec_t       tbl[9];
   logic [7:0] v;

   initial begin
      tbl = '{'{3'd1, 8'hFF, 8'hFF}, '{3'd3, 8'h3C, 8'h3C}, '{3'd4, 8'hC3, 8'hC3},
              '{3'd5, 8'h5A, 8'h5A}, '{3'd6, 8'hFF, 8'h00}, '{3'd2, 8'hFF, 8'h00},
              '{3'd7, 8'hFF, 8'h00}, '{3'd0, 8'h5A, 8'h5A}, '{3'd0, 8'hA5, 8'hA5}};
      step(2);
      chk("reset_data_out", data_out, 0);
      chk("reset_dir_ctrl", dir_ctrl, 0);
      chk("reset_irq", irq, 0);
      chk("reset_rd_valid", reg_rd_valid, 0);
      rst_n = 1;
      chk_en = 1;

      foreach (tbl[k]) begin
         wr(tbl[k].a, tbl[k].d);
         rd(tbl[k].a, v);
         chk($sformatf("tbl_rd_addr%0d", tbl[k].a), v, tbl[k].exp);
      end
      chk("t1_dir_ctrl", dir_ctrl, 8'hFF);
      chk("t1_data_out", data_out, 8'hA5);
      step();
      chk("t1_rd_valid_drop", reg_rd_valid, 0);
      reg_wr_en = 1; reg_wr_addr = 0; reg_wr_data = 8'h11;
      reg_rd_en = 1; reg_rd_addr = 0;
      step();
      reg_wr_en = 0; reg_rd_en = 0;
      chk("rw_same_addr_old", reg_rd_data, 8'hA5);
      chk("rw_same_addr_new", data_out, 8'h11);

      // T2: rise on pin0 appears on the 7th edge
      wr(3, 8'h01); wr(4, 8'h01); wr(5, 8'h00);
      data_in = 8'h01;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk($sformatf("t2_event_edge%0d", k), irq_event[0], k == 7);
         if (k == 7) chk("t2_irq", irq, 1);
      end
      rd(6, v); chk("t2_status", v, 8'h01);

      // T3: 3-sample glitch on pin3 is filtered
      wr(4, 8'h09);
      data_in = 8'h09;
      step(3);
      data_in = 8'h01;
      for (int k = 0; k < 12; k++) begin
         step();
         chk("t3_no_event", irq_event[3], 0);
      end
      rd(2, v); chk("t3_data_in", v, 8'h01);
      rd(6, v); chk("t3_status", v, 8'h01);

      // T4: w1c coincides with a new qualified fall on pin0
      wr(5, 8'h01);
      data_in = 8'h00;
      step(6);
      reg_wr_en = 1; reg_wr_addr = 6; reg_wr_data = 8'h01;
      step();
      reg_wr_en = 0;
      chk("t4_event", irq_event[0], 1);
      rd(6, v); chk("t4_set_wins", v, 8'h01);
      chk("t4_irq_held", irq, 1);
      wr(6, 8'h01);
      chk("t4_irq_cleared", irq, 0);
      rd(6, v); chk("t4_status_cleared", v, 8'h00);

      // T5: status latches while masked, unmasking raises irq
      wr(3, 8'h00); wr(4, 8'h00); wr(5, 8'h80);
      data_in = 8'h80; step(10);
      data_in = 8'h00; step(10);
      chk("t5_irq_masked", irq, 0);
      rd(6, v); chk("t5_status", v, 8'h80);
      wr(3, 8'h80);
      chk("t5_irq_unmasked", irq, 1);
      wr(6, 8'h80);
      chk("t5_irq_cleared", irq, 0);

      // T6: reset mid-debounce
      wr(0, 8'h3C); wr(1, 8'hF0); wr(4, 8'hFF); wr(3, 8'hFF);
      data_in = 8'hFF;
      step(3);
      rst_n = 0;
      step();
      chk("t6_data_out", data_out, 0);
      chk("t6_dir_ctrl", dir_ctrl, 0);
      chk("t6_irq_event", irq_event, 0);
      chk("t6_irq", irq, 0);
      chk("t6_rd_data", reg_rd_data, 0);
      chk("t6_rd_valid", reg_rd_valid, 0);
      rst_n = 1;
      for (int k = 0; k < 12; k++) begin
         step();
         chk("t6_no_irq", irq, 0);
      end
      rd(2, v); chk("t6_data_in", v, 8'hFF);
      rd(6, v); chk("t6_status", v, 8'h00);

      // random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         for (int b = 0; b < 8; b++)
            if ($urandom_range(0, 23) == 0) data_in[b] = ~data_in[b];
         reg_wr_en   = $urandom_range(0, 3) == 0;
         reg_wr_addr = 3'($urandom);
         reg_wr_data = 8'($urandom);
         reg_rd_en   = $urandom_range(0, 2) == 0;
         reg_rd_addr = 3'($urandom);
         rst_n       = $urandom_range(0, 599) != 0;
         step();
      end
      reg_wr_en = 0; reg_rd_en = 0; rst_n = 1;
      step(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
